// File: rtl/regfile_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared types and helpers for the register-file write front
//               end: controller state encoding, address range test and the
//               width of the error-port report.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int ERR_PORT_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Arguments are widened to 32 bits by the caller so one helper serves
  // every address width.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches from i_ptr
//               upward (modulo num_req) for the first asserted request.
// Ports       : i_req   - request vector
//               i_ptr   - search start index (register held by the parent)
//               o_grant - one-hot grant, all zero when no request
//               o_idx   - index of the granted request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int num_req = 4,
  parameter int PTR_W   = $clog2(num_req)
) (
  input  logic [num_req-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [num_req-1:0] o_grant,
  output logic [PTR_W-1:0]   o_idx
);

  logic             w_found;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < num_req; k++) begin
      // One extra bit keeps ptr+k from overflowing before the modulo fold.
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(num_req)) begin
        w_sum = w_sum - (PTR_W+1)'(num_req);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_ctrl
// Description : Write-side front end of the register file. Round-robin
//               arbitrates num_req valid/ready clients onto the single
//               registered write port and runs a clear sweep lo..hi.
// Ports       : CLK, RST           - clock, synchronous active-high reset
//               req_valid/ready    - per-client handshake
//               req_addr/req_data  - packed per-client address / data
//               clr_start          - pulse to start a clear sweep
//               clr_busy/clr_done  - sweep status / completion pulse
//               err_oob/err_port   - out-of-range request report
//               ADDR_IN/D_IN/WE    - registered register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_ctrl
  import regfile_pkg::*;
#(
  parameter int              addr_width = 5,
  parameter int              data_width = 32,
  parameter int              lo         = 0,
  parameter int              hi         = 31,
  parameter int              num_req    = 4,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [num_req-1:0]            req_valid,
  output logic [num_req-1:0]            req_ready,
  input  logic [num_req*addr_width-1:0] req_addr,
  input  logic [num_req*data_width-1:0] req_data,
  input  logic                          clr_start,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          err_oob,
  output logic [ERR_PORT_W-1:0]         err_port,
  output logic [addr_width-1:0]         ADDR_IN,
  output logic [data_width-1:0]         D_IN,
  output logic                          WE
);

  localparam int PTR_W = $clog2(num_req);
  // One spare bit so the counter never wraps when hi is the top address.
  localparam int CNT_W = addr_width + 1;

  state_t                  r_state;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we;
  logic [addr_width-1:0]   r_addr;
  logic [data_width-1:0]   r_data;
  logic                    r_clr_busy;
  logic                    r_clr_done;
  logic                    r_err_oob;
  logic [ERR_PORT_W-1:0]   r_err_port;

  logic [num_req-1:0]      w_grant;
  logic [PTR_W-1:0]        w_idx;
  logic                    w_arb_en;
  logic                    w_accept;
  logic [addr_width-1:0]   w_sel_addr;
  logic [data_width-1:0]   w_sel_data;
  logic                    w_sel_in;
  logic [PTR_W-1:0]        w_ptr_next;

  rr_arbiter #(
    .num_req (num_req),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // A sweep request wins over clients in the cycle it arrives; no grant is
  // offered while reset is asserted so nothing is consumed and then lost.
  assign w_arb_en   = (r_state == IDLE) && !clr_start && !RST;
  assign req_ready  = w_arb_en ? w_grant : '0;
  assign w_accept   = |req_ready;
  assign w_sel_addr = req_addr[w_idx*addr_width +: addr_width];
  assign w_sel_data = req_data[w_idx*data_width +: data_width];
  assign w_sel_in   = in_range(32'(w_sel_addr), 32'(lo), 32'(hi));
  assign w_ptr_next = (w_idx == PTR_W'(num_req - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_err_oob  <= 1'b0;
      r_err_port <= '0;
    end else begin
      r_we       <= 1'b0;
      r_clr_done <= 1'b0;
      r_err_oob  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_cnt      <= CNT_W'(lo);
            r_clr_busy <= 1'b1;
            r_state    <= CLEAR;
          end else if (w_accept) begin
            r_rr_ptr <= w_ptr_next;
            if (w_sel_in) begin
              r_we   <= 1'b1;
              r_addr <= w_sel_addr;
              r_data <= w_sel_data;
            end else begin
              // Request is consumed but the write is dropped.
              r_err_oob  <= 1'b1;
              r_err_port <= ERR_PORT_W'(w_idx);
            end
          end
        end
        CLEAR: begin
          r_we   <= 1'b1;
          r_addr <= r_cnt[addr_width-1:0];
          r_data <= init_value;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(hi)) begin
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign WE       = r_we;
  assign ADDR_IN  = r_addr;
  assign D_IN     = r_data;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
  assign err_oob  = r_err_oob;
  assign err_port = r_err_port;

endmodule
`default_nettype wire
